// File: rtl/perceptron_frame_loader.sv
// -----------------------------------------------------------------------------
// perceptron_frame_loader
//
// Accepts a valid/ready byte stream carrying framed load commands and stages
// the operands of a combinational perceptron. A complete frame is committed to
// the operand outputs in a single cycle, so the perceptron never sees a mixed
// old/new operand set. The cycle after the commit, the perceptron's output is
// captured into o_result_q. Bad headers and frames that stall for TIMEOUT
// consecutive cycles are flagged.
//
// Frames:
//   0xA5 + 10 bytes : in0..in3, weight0..weight3, bias, threshold
//   0x5A +  4 bytes : in0..in3 (weights, bias, threshold kept)
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_data_in/i_data_valid stream byte and its valid strobe
//   o_ready                byte can be accepted this cycle (decoded from state)
//   i_result_in            perceptron output, combinational from operands
//   o_in0..o_in3           committed perceptron inputs
//   o_weight0..o_weight3   committed shift weights
//   o_bias, o_threshold    committed bias and threshold
//   o_result_q             captured perceptron result
//   o_result_valid         one-cycle pulse when o_result_q updates
//   o_err_pulse            one-cycle pulse on a frame error
//   o_err_code             sticky last error: 00 none, 01 bad header, 10 timeout
//   o_frame_count          committed frames, modulo 256
// -----------------------------------------------------------------------------
module perceptron_frame_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data_in,
  input  logic       i_data_valid,
  output logic       o_ready,
  input  logic [7:0] i_result_in,
  output logic [7:0] o_in0,
  output logic [7:0] o_in1,
  output logic [7:0] o_in2,
  output logic [7:0] o_in3,
  output logic [7:0] o_weight0,
  output logic [7:0] o_weight1,
  output logic [7:0] o_weight2,
  output logic [7:0] o_weight3,
  output logic [7:0] o_bias,
  output logic [7:0] o_threshold,
  output logic [7:0] o_result_q,
  output logic       o_result_valid,
  output logic       o_err_pulse,
  output logic [1:0] o_err_code,
  output logic [7:0] o_frame_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_CAPTURE
  } state_t;

  localparam logic [7:0]  HDR_FULL  = 8'hA5;
  localparam logic [7:0]  HDR_INPUT = 8'h5A;
  localparam logic [1:0]  ERR_NONE  = 2'b00;
  localparam logic [1:0]  ERR_HDR   = 2'b01;
  localparam logic [1:0]  ERR_TOUT  = 2'b10;
  // Idle count seen during the cycle that ends the TIMEOUT-th idle cycle.
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_full;          // 1: full frame, 0: input-only frame
  logic [3:0]  r_idx;
  logic [15:0] r_idle;
  logic [7:0]  r_stage [10];
  logic [7:0]  r_op    [10];    // committed operands, same order as payload

  logic w_accept;
  logic w_last;
  logic w_timeout;

  assign o_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept  = i_data_valid && o_ready;
  assign w_last    = r_full ? (r_idx == 4'd9) : (r_idx == 4'd3);
  // A valid byte in the would-be timeout cycle wins, hence the !i_data_valid.
  assign w_timeout = (r_state == S_LOAD) && !i_data_valid && (r_idle == IDLE_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept && (i_data_in == HDR_FULL || i_data_in == HDR_INPUT))
                   w_next = S_LOAD;
      S_LOAD:    if (w_accept && w_last) w_next = S_COMMIT;
                 else if (w_timeout)     w_next = S_IDLE;
      S_COMMIT:  w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: the staging array is small and reset alongside the rest so a frame
  // aborted by reset cannot leak stale bytes; larger memories would not be.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full         <= 1'b0;
      r_idx          <= '0;
      r_idle         <= '0;
      o_result_q     <= '0;
      o_result_valid <= 1'b0;
      o_err_pulse    <= 1'b0;
      o_err_code     <= ERR_NONE;
      o_frame_count  <= '0;
      for (int i = 0; i < 10; i++) begin
        r_stage[i] <= '0;
        r_op[i]    <= '0;
      end
    end else begin
      o_result_valid <= 1'b0;
      o_err_pulse    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (i_data_in == HDR_FULL || i_data_in == HDR_INPUT) begin
              r_full <= (i_data_in == HDR_FULL);
              r_idx  <= '0;
              r_idle <= '0;
            end else begin
              o_err_pulse <= 1'b1;
              o_err_code  <= ERR_HDR;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_stage[r_idx] <= i_data_in;
            r_idx          <= r_idx + 4'd1;
            r_idle         <= '0;
          end else if (w_timeout) begin
            o_err_pulse <= 1'b1;
            o_err_code  <= ERR_TOUT;
          end else begin
            r_idle <= r_idle + 16'd1;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < 10; i++)
            if (r_full || i < 4) r_op[i] <= r_stage[i];
          o_frame_count <= o_frame_count + 8'd1;
          o_err_code    <= ERR_NONE;
        end
        S_CAPTURE: begin
          o_result_q     <= i_result_in;
          o_result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_in0       = r_op[0];
  assign o_in1       = r_op[1];
  assign o_in2       = r_op[2];
  assign o_in3       = r_op[3];
  assign o_weight0   = r_op[4];
  assign o_weight1   = r_op[5];
  assign o_weight2   = r_op[6];
  assign o_weight3   = r_op[7];
  assign o_bias      = r_op[8];
  assign o_threshold = r_op[9];

endmodule

// File: tb/tb_perceptron_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_perceptron_frame_loader
//
// Directed bench for perceptron_frame_loader built with TIMEOUT=4. A simple
// combinational stand-in for the perceptron drives i_result_in:
//   out = in0*w0 + in1*w1 + in2*w2 + in3*w3 + threshold  (mod 256)
// which yields 0x1E for the reference frame.
// -----------------------------------------------------------------------------
module tb_perceptron_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic [7:0] result_in;
  logic [7:0] in0, in1, in2, in3;
  logic [7:0] w0, w1, w2, w3;
  logic [7:0] bias, threshold;
  logic [7:0] result_q;
  logic       result_valid;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_err_pulses = 0;

  always #5 clk = ~clk;

  assign result_in = in0 * w0 + in1 * w1 + in2 * w2 + in3 * w3 + threshold;

  always @(posedge clk) if (err_pulse) n_err_pulses++;

  perceptron_frame_loader #(.TIMEOUT(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_data_in      (data_in),
    .i_data_valid   (data_valid),
    .o_ready        (ready),
    .i_result_in    (result_in),
    .o_in0          (in0),
    .o_in1          (in1),
    .o_in2          (in2),
    .o_in3          (in3),
    .o_weight0      (w0),
    .o_weight1      (w1),
    .o_weight2      (w2),
    .o_weight3      (w3),
    .o_bias         (bias),
    .o_threshold    (threshold),
    .o_result_q     (result_q),
    .o_result_valid (result_valid),
    .o_err_pulse    (err_pulse),
    .o_err_code     (err_code),
    .o_frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte presented for exactly one rising edge; returns 1 time unit later.
  task automatic send(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] full_frame [11];
    full_frame = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h0A};
    rst        = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  ready, 1);
    check("rst_in0",    in0, 0);
    check("rst_thr",    threshold, 0);
    check("rst_resq",   result_q, 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_errp",   err_pulse, 0);
    check("rst_errc",   err_code, 0);
    check("rst_fcnt",   frame_count, 0);
    rst = 1'b0;

    // Full frame with valid held high.
    for (int i = 0; i < 11; i++) send(full_frame[i]);
    check("ff_hold_in0",   in0, 0);
    check("ff_commit_rdy", ready, 0);
    tick();
    check("ff_in0",  in0, 8'h01);
    check("ff_in3",  in3, 8'h04);
    check("ff_w0",   w0, 8'h00);
    check("ff_w3",   w3, 8'h03);
    check("ff_bias", bias, 8'h05);
    check("ff_thr",  threshold, 8'h0A);
    check("ff_fcnt", frame_count, 1);
    check("ff_rv_early", result_valid, 0);
    check("ff_cap_rdy", ready, 0);
    tick();
    check("ff_resq", result_q, 8'h1E);
    check("ff_rv",   result_valid, 1);
    check("ff_rdy",  ready, 1);
    tick();
    check("ff_rv_end", result_valid, 0);

    // Input frame: only in0..in3 replaced. 0x20+0x60+0xC0+0x0A = 0x14A.
    send(8'h5A); send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    tick();
    check("if_in0",  in0, 8'h10);
    check("if_in3",  in3, 8'h40);
    check("if_w1",   w1, 8'h01);
    check("if_bias", bias, 8'h05);
    check("if_thr",  threshold, 8'h0A);
    check("if_fcnt", frame_count, 2);
    tick();
    check("if_rv",   result_valid, 1);
    check("if_resq", result_q, 8'h4A);

    // Bad header.
    send(8'h33);
    check("bh_errp", err_pulse, 1);
    check("bh_errc", err_code, 2'b01);
    check("bh_in0",  in0, 8'h10);
    tick();
    check("bh_errp_end", err_pulse, 0);
    check("bh_errc_hold", err_code, 2'b01);
    send(8'h5A); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick();
    check("bh_clr_errc", err_code, 2'b00);
    check("bh_clr_fcnt", frame_count, 3);
    tick();
    check("bh_clr_resq", result_q, 8'h1E);

    // Timeout: A5,01 then four idle cycles.
    send(8'hA5); send(8'h01);
    repeat (3) tick();
    check("to_no_early", err_pulse, 0);
    tick();
    check("to_errp", err_pulse, 1);
    check("to_errc", err_code, 2'b10);
    check("to_in0",  in0, 8'h01);
    check("to_w3",   w3, 8'h03);
    check("to_fcnt", frame_count, 3);
    tick();
    check("to_errp_end", err_pulse, 0);

    // Byte on the 4th idle cycle wins; the frame then completes.
    send(8'hA5); send(8'h01);
    repeat (3) tick();
    send(8'h02);
    check("tw_no_abort", err_pulse, 0);
    for (int i = 3; i < 11; i++) send(full_frame[i]);
    tick();
    check("tw_fcnt", frame_count, 4);
    check("tw_errc", err_code, 2'b00);
    check("tw_in1",  in1, 8'h02);
    check("tw_thr",  threshold, 8'h0A);
    tick();
    check("tw_resq", result_q, 8'h1E);

    // Reset after 6 payload bytes.
    send(8'hA5);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h01); send(8'h01);
    rst = 1'b1;
    tick();
    check("mr_in0",  in0, 0);
    check("mr_w3",   w3, 0);
    check("mr_thr",  threshold, 0);
    check("mr_resq", result_q, 0);
    check("mr_fcnt", frame_count, 0);
    check("mr_rdy",  ready, 1);
    check("mr_errp", err_pulse, 0);
    rst = 1'b0;
    // 2*1+3*1+4*1+5*1 + 0 = 0x0E
    send(8'hA5);
    send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    send(8'h01); send(8'h01); send(8'h01); send(8'h01);
    send(8'h07); send(8'h00);
    tick();
    check("mr_new_in2",  in2, 8'h04);
    check("mr_new_bias", bias, 8'h07);
    check("mr_new_fcnt", frame_count, 1);
    check("mr_new_errc", err_code, 0);
    tick();
    check("mr_new_resq", result_q, 8'h0E);

    // 256 input frames from a fresh reset, with valid held through COMMIT/CAPTURE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_err_pulses = 0;
    for (int f = 0; f < 256; f++) begin
      send(8'h5A); send(8'(f)); send(8'h00); send(8'h00); send(8'h00);
      data_in    = 8'h77;
      data_valid = 1'b1;
      repeat (2) tick();
      data_valid = 1'b0;
      if (f == 254) check("wr_fcnt_255", frame_count, 8'hFF);
    end
    check("wr_fcnt_0",  frame_count, 0);
    check("wr_in0",     in0, 8'hFF);
    check("wr_in1",     in1, 8'h00);
    check("wr_errp_cnt", n_err_pulses, 0);
    check("wr_errc",    err_code, 0);
    check("wr_rdy",     ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
